// File: rtl/if_id_buffer.sv
// ---------------------------------------------------------------------------
// if_id_buffer
//
// Purpose:
//   An elastic buffer between the instruction-fetch stage and the decode
//   stage. Each accepted {PC+1, instruction} pair goes into a small circular
//   FIFO. The oldest pair is offered to decode through a valid/ready
//   handshake. Fetch is back-pressured through if_ready, so a decode stall
//   never loses an instruction. A flush (branch taken further down the pipe)
//   drops everything buffered and the pair fetch presents in that cycle.
//
// Parameters:
//   DEPTH           number of entries (power of two, minimum 2)
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous reset, active low
//   flush           discard all buffered and incoming entries
//   if_valid        fetch presents a pair this cycle
//   if_pc           PC+1 from fetch
//   if_instruction  instruction word from fetch
//   if_ready        buffer can accept (fetch freezes while low)
//   id_valid        head entry valid toward decode
//   id_ready        decode accepts the head this cycle
//   id_pc           head entry PC+1 (0 while empty)
//   id_instruction  head entry instruction (0 / NOP while empty)
//   stall_cycles    refused-push cycle counter (IF_ID_PERF_EN only)
//   flush_count     flush cycle counter (IF_ID_PERF_EN only)
//
// Configuration macro:
//   IF_ID_PERF_EN   when defined, adds the stall_cycles and flush_count
//                   performance counters and their output ports.
// ---------------------------------------------------------------------------
module if_id_buffer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instruction,
  output logic        if_ready,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instruction
`ifdef IF_ID_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [63:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic [63:0]      head;

  // if_ready comes only from registered occupancy. A full buffer therefore
  // refuses a push even when decode pops in the same cycle. This keeps
  // id_ready out of the fetch freeze path.
  assign if_ready = (count != FULL_COUNT);
  assign id_valid = (count != '0);

  // Flush masks both handshakes. The dropped fetch pair never lands, and
  // decode never sees a pop in a flush cycle.
  assign push = if_valid & if_ready & ~flush;
  assign pop  = id_valid & id_ready & ~flush;

  // The head is read straight from the array. It is gated to zero while
  // the buffer is empty, so decode sees a NOP instead of stale storage.
  assign head           = mem[rd_ptr];
  assign id_pc          = id_valid ? head[63:32] : 32'h0;
  assign id_instruction = id_valid ? head[31:0]  : 32'h0;

  // Pointer and occupancy state. Because DEPTH is a power of two, the
  // pointers wrap on their own. Flush takes priority over everything else.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is never cleared. Only the pointers define which slots are live,
  // so the array needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {if_pc, if_instruction};
    end
  end

`ifdef IF_ID_PERF_EN
  // A stall is a cycle where fetch has a pair but the buffer is full.
  // Flush cycles are excluded, because that pair is dropped anyway.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= 32'h0;
      flush_count  <= 32'h0;
    end else begin
      if (if_valid & ~if_ready & ~flush) begin
        stall_cycles <= stall_cycles + 32'h1;
      end
      if (flush) begin
        flush_count <= flush_count + 32'h1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// ---------------------------------------------------------------------------
// tb_if_id_buffer
//
// Purpose:
//   Self-checking bench for if_id_buffer (DEPTH = 2). The reference model is
//   a queue of accepted {pc, instruction} pairs. Pushes are appended when
//   the model has room. A monitor compares the DUT outputs with the queue
//   every cycle and pops the head on each decode handshake. A flush empties
//   the queue.
//
// Configuration macro:
//   IF_ID_PERF_EN   also models and checks stall_cycles / flush_count.
// ---------------------------------------------------------------------------
module tb_if_id_buffer;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instruction;
  logic        if_ready;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instruction;
`ifdef IF_ID_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  int errors = 0;
  int checks = 0;

  logic [63:0] exp_q[$];
  bit          was_full = 1'b0;
  int unsigned model_stalls = 0;
  int unsigned model_flushes = 0;

  if_id_buffer #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instruction (if_instruction),
    .if_ready       (if_ready),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instruction (id_instruction)
`ifdef IF_ID_PERF_EN
    ,
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs change 2 time units after a rising edge. They then stay stable
  // through the monitor's falling-edge sample and the next rising edge.
  task automatic applyStimulus(input logic v, input logic [31:0] pc,
                               input logic [31:0] ins, input logic rdy,
                               input logic fl, input logic r);
    @(posedge clk);
    #2;
    rst            = r;
    if_valid       = v;
    if_pc          = pc;
    if_instruction = ins;
    id_ready       = rdy;
    flush          = fl;
  endtask

  // Reference model update at the edge. A push is accepted only if the
  // buffer was not full before any same-cycle pop.
  always @(posedge clk) begin
    if (!rst) begin
      exp_q.delete();
      model_stalls  = 0;
      model_flushes = 0;
    end else begin
      if (flush) begin
        exp_q.delete();
        model_flushes++;
      end else if (if_valid && !was_full) begin
        exp_q.push_back({if_pc, if_instruction});
      end
      if (if_valid && was_full && !flush) model_stalls++;
    end
  end

  // Monitor: compares the DUT outputs with the model in the middle of the
  // cycle, then retires the head when decode takes it.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("reset if_ready", {31'h0, if_ready}, 32'h1);
      checkOutput("reset id_valid", {31'h0, id_valid}, 32'h0);
      checkOutput("reset id_pc", id_pc, 32'h0);
      checkOutput("reset id_instruction", id_instruction, 32'h0);
`ifdef IF_ID_PERF_EN
      checkOutput("reset stall_cycles", stall_cycles, 32'h0);
      checkOutput("reset flush_count", flush_count, 32'h0);
`endif
      was_full = 1'b0;
    end else begin
      logic [63:0] head;
      int          occ;
      occ  = exp_q.size();
      head = (occ != 0) ? exp_q[0] : 64'h0;
      checkOutput("if_ready", {31'h0, if_ready}, {31'h0, occ != DEPTH});
      checkOutput("id_valid", {31'h0, id_valid}, {31'h0, occ != 0});
      checkOutput("id_pc", id_pc, head[63:32]);
      checkOutput("id_instruction", id_instruction, head[31:0]);
`ifdef IF_ID_PERF_EN
      checkOutput("stall_cycles", stall_cycles, model_stalls);
      checkOutput("flush_count", flush_count, model_flushes);
`endif
      was_full = (occ == DEPTH);
      if (occ != 0 && id_ready && !flush) void'(exp_q.pop_front());
    end
  end

  initial begin
    logic [31:0] next_pc;
    rst = 1'b0; flush = 1'b0; if_valid = 1'b0; if_pc = '0;
    if_instruction = '0; id_ready = 1'b0;

    // Reset held with fetch valid, then release; the first pair lands next.
    for (int i = 0; i < 3; i++) applyStimulus(1, 32'd1, 32'hE3A00001, 0, 0, 0);
    applyStimulus(1, 32'd1, 32'hE3A00001, 0, 0, 1);
    applyStimulus(0, 32'd0, 32'h0, 0, 0, 1);
    applyStimulus(0, 32'd0, 32'h0, 1, 0, 1);
    applyStimulus(0, 32'd0, 32'h0, 1, 0, 1);

    // Streaming: eight back-to-back pairs with decode always ready.
    for (int i = 1; i <= 8; i++) applyStimulus(1, 32'(i), 32'hA000_0000 + 32'(i), 1, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0, 32'h0, 1, 0, 1);

    // Back-pressure: fill while decode stalls, hold pc=3, then drain.
    applyStimulus(1, 32'd1, 32'hB0000001, 0, 0, 1);
    applyStimulus(1, 32'd2, 32'hB0000002, 0, 0, 1);
    applyStimulus(1, 32'd3, 32'hB0000003, 0, 0, 1);
    applyStimulus(1, 32'd3, 32'hB0000003, 1, 0, 1);
    applyStimulus(1, 32'd3, 32'hB0000003, 1, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 32'h0, 32'h0, 1, 0, 1);

    // Simultaneous push/pop at occupancy one across pointer wraps.
    applyStimulus(1, 32'h10, 32'hC0000010, 0, 0, 1);
    for (int i = 1; i <= 10; i++) applyStimulus(1, 32'h10 + 32'(i), 32'hC0000010 + 32'(i), 1, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0, 32'h0, 1, 0, 1);

    // Flush with two entries held plus an incoming pair; pc=0x40 follows.
    applyStimulus(1, 32'h20, 32'hD0000020, 0, 0, 1);
    applyStimulus(1, 32'h21, 32'hD0000021, 0, 0, 1);
    applyStimulus(1, 32'h22, 32'hD0000022, 1, 1, 1);
    applyStimulus(1, 32'h40, 32'hD0000040, 0, 0, 1);
    applyStimulus(0, 32'h0, 32'h0, 1, 0, 1);
    for (int i = 0; i < 2; i++) applyStimulus(0, 32'h0, 32'h0, 1, 0, 1);

    // Five refused pushes and two flushes, then a reset to clear counters.
    applyStimulus(1, 32'h50, 32'hE0000050, 0, 0, 1);
    applyStimulus(1, 32'h51, 32'hE0000051, 0, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(1, 32'h52, 32'hE0000052, 0, 0, 1);
    applyStimulus(0, 32'h0, 32'h0, 0, 1, 1);
    applyStimulus(0, 32'h0, 32'h0, 0, 0, 1);
    applyStimulus(0, 32'h0, 32'h0, 0, 1, 1);
    applyStimulus(0, 32'h0, 32'h0, 0, 0, 1);
    applyStimulus(1, 32'h60, 32'hE0000060, 0, 0, 1);
    applyStimulus(0, 32'h0, 32'h0, 0, 0, 0);
    applyStimulus(0, 32'h0, 32'h0, 0, 0, 0);
    applyStimulus(0, 32'h0, 32'h0, 0, 0, 1);

    // Randomised traffic with occasional flushes.
    next_pc = 32'h100;
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), next_pc, $urandom,
                    1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 15) == 0), 1);
      next_pc = next_pc + 32'h1;
    end
    for (int i = 0; i < 4; i++) applyStimulus(0, 32'h0, 32'h0, 1, 0, 1);

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
